stream_fifo: RTL and testbench



---
 rtl/stream_fifo_pkg.sv | 21 ++
 rtl/stream_fifo_ram.sv | 24 ++
 rtl/stream_fifo.sv | 117 +++++++++++
 tb/tb_stream_fifo.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// Shared definitions for the streaming FIFOs in the datapath.
// Includes the count-width helper and the head-register load source encoding.
package stream_fifo_pkg;

  // Occupancy counters need one extra bit so they can represent a completely full FIFO.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  typedef enum logic [1:0] {
    HEAD_HOLD     = 2'd0,
    HEAD_FROM_RAM = 2'd1,
    HEAD_BYPASS   = 2'd2,
    HEAD_DRAIN    = 2'd3
  } head_src_e;

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port storage for stream_fifo.
// It is kept separate so a BRAM/URAM macro can be swapped in.
module fifo_ram #(
  parameter int D_W   = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  logic [D_W-1:0] wdata,
  input  logic [AW-1:0]  raddr,
  output logic [D_W-1:0] rdata
);

  logic [D_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with a registered head word.
// Words are held in a RAM; flush is a synchronous clear that discards the contents.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int D_W       = 32,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [D_W-1:0]            s_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [D_W-1:0]            m_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      almost_full,
  output logic                      almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_CNT = CW'(AEMPTY_TH);

  generate
    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_depth_chk
      $error("stream_fifo: DEPTH must be a power of two and at least 2");
    end
    if (!(AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_th_chk
      $error("stream_fifo: thresholds must satisfy AEMPTY_TH < AFULL_TH <= DEPTH");
    end
  endgenerate

  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [D_W-1:0] ram_rdata;
  logic           push;
  logic           pop;
  logic           head_load;
  logic           ram_empty;
  logic           ram_we;
  head_src_e      head_src;

  assign s_ready   = (count != FULL_CNT) && !flush;
  assign push      = s_valid && s_ready;
  assign pop       = m_valid && m_ready;
  assign head_load = !m_valid || m_ready;
  // RAM holds at most DEPTH-1 words (the head register holds one more), so equal pointers mean empty.
  assign ram_empty = (wr_ptr == rd_ptr);

  always_comb begin
    head_src = HEAD_HOLD;
    if (head_load) begin
      if (!ram_empty)
        head_src = HEAD_FROM_RAM;
      else if (push)
        head_src = HEAD_BYPASS;
      else
        head_src = HEAD_DRAIN;
    end
  end

  assign ram_we = push && (head_src != HEAD_BYPASS);

  fifo_ram #(
    .D_W   (D_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (s_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      m_valid <= 1'b0;
    end else begin
      if (ram_we) wr_ptr <= wr_ptr + AW'(1);
      case (head_src)
        HEAD_FROM_RAM: begin
          m_valid <= 1'b1;
          rd_ptr  <= rd_ptr + AW'(1);
        end
        HEAD_BYPASS: m_valid <= 1'b1;
        HEAD_DRAIN:  m_valid <= 1'b0;
        default:     m_valid <= m_valid;
      endcase
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // The head word itself carries no reset; it is only meaningful while m_valid is high.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (head_src == HEAD_FROM_RAM)
        m_data <= ram_rdata;
      else if (head_src == HEAD_BYPASS)
        m_data <= s_data;
    end
  end

  assign almost_full  = (count >= AFULL_CNT);
  assign almost_empty = (count <= AEMPTY_CNT);

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo against a queue-based reference model.
// Every cycle is driven through applyStimulus; each test task checks its own expectations.
module tb_stream_fifo;

  localparam int DEPTH     = 16;
  localparam int AFULL_TH  = DEPTH - 2;
  localparam int AEMPTY_TH = 2;
  localparam int CW        = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          s_valid;
  logic          s_ready;
  logic [31:0]   s_data;
  logic          m_valid;
  logic          m_ready;
  logic [31:0]   m_data;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;

  int total = 0;
  int bad   = 0;

  logic [31:0] model[$];
  bit          last_push;

  stream_fifo #(
    .D_W       (32),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive inputs, advance the model by the handshake rules, sample 1 ns after the edge.
  task automatic applyStimulus(input logic sv, input logic [31:0] sd, input logic mr,
                               input logic fl, input logic rs);
    bit mpush;
    bit mpop;
    s_valid = sv;
    s_data  = sd;
    m_ready = mr;
    flush   = fl;
    rst     = rs;
    mpush = sv && (model.size() < DEPTH) && !fl && !rs;
    mpop  = mr && (model.size() > 0);
    @(posedge clk);
    if (rs || fl) begin
      model.delete();
    end else begin
      if (mpop) void'(model.pop_front());
      if (mpush) model.push_back(sd);
    end
    last_push = mpush;
    #1;
  endtask

  task automatic test_reset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    total++;
    if (s_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_s_ready got=%b want=1", s_ready); end
    total++;
    if (m_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_m_valid got=%b want=0", m_valid); end
    total++;
    if (count !== '0) begin bad++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
    total++;
    if (almost_full !== 1'b0) begin bad++; $display("[TB] FAIL reset_afull got=%b want=0", almost_full); end
    total++;
    if (almost_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_aempty got=%b want=1", almost_empty); end
  endtask

  task automatic test_single_push();
    applyStimulus(1'b1, 32'h0000_00A5, 1'b0, 1'b0, 1'b0);
    total++;
    if (m_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_m_valid got=%b want=1", m_valid); end
    total++;
    if (m_data !== 32'h0000_00A5) begin bad++; $display("[TB] FAIL single_m_data got=%h want=000000a5", m_data); end
    total++;
    if (count !== CW'(1)) begin bad++; $display("[TB] FAIL single_count got=%0d want=1", count); end
    total++;
    if (almost_empty !== 1'b1) begin bad++; $display("[TB] FAIL single_aempty got=%b want=1", almost_empty); end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    total++;
    if (m_valid !== 1'b0 || count !== '0) begin
      bad++; $display("[TB] FAIL single_drain got=valid%b/cnt%0d want=valid0/cnt0", m_valid, count);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      total++;
      if (count !== CW'(i)) begin bad++; $display("[TB] FAIL fill_count got=%0d want=%0d", count, i); end
      total++;
      if (almost_full !== (i >= AFULL_TH)) begin
        bad++; $display("[TB] FAIL fill_afull at=%0d got=%b want=%b", i, almost_full, i >= AFULL_TH);
      end
      total++;
      if (s_ready !== (i < DEPTH)) begin
        bad++; $display("[TB] FAIL fill_s_ready at=%0d got=%b want=%b", i, s_ready, i < DEPTH);
      end
    end
    applyStimulus(1'b1, 32'd17, 1'b0, 1'b0, 1'b0);
    total++;
    if (count !== CW'(DEPTH)) begin bad++; $display("[TB] FAIL fill_overflow_count got=%0d want=%0d", count, DEPTH); end
    for (int i = 1; i <= DEPTH; i++) begin
      total++;
      if (m_valid !== 1'b1 || m_data !== 32'(i)) begin
        bad++; $display("[TB] FAIL drain_order got=valid%b/%0d want=valid1/%0d", m_valid, m_data, i);
      end
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    total++;
    if (m_valid !== 1'b0 || count !== '0) begin
      bad++; $display("[TB] FAIL drain_empty got=valid%b/cnt%0d want=valid0/cnt0", m_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
      total++;
      if (count !== CW'(1) || m_data !== 32'h100 + 32'(i)) begin
        bad++; $display("[TB] FAIL stream_bypass got=cnt%0d/%h want=cnt1/%h", count, m_data, 32'h100 + 32'(i));
      end
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0);
    for (int i = 5; i < 69; i++) begin
      applyStimulus(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0);
      total++;
      if (count !== CW'(5) || m_data !== 32'h200 + 32'(i - 4)) begin
        bad++; $display("[TB] FAIL stream_wrap got=cnt%0d/%h want=cnt5/%h", count, m_data, 32'h200 + 32'(i - 4));
      end
    end
    for (int i = 0; i < 40 && model.size() > 0; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      if (model.size() > 0) begin
        total++;
        if (m_data !== model[0]) begin bad++; $display("[TB] FAIL stream_tail got=%h want=%h", m_data, model[0]); end
      end
    end
  endtask

  task automatic test_full_pulse();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 32'd101 + 32'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd77, 1'b1, 1'b0, 1'b0);
    total++;
    if (count !== CW'(DEPTH - 1) || s_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL pulse_pop got=cnt%0d/rdy%b want=cnt%0d/rdy1", count, s_ready, DEPTH - 1);
    end
    applyStimulus(1'b1, 32'd77, 1'b0, 1'b0, 1'b0);
    total++;
    if (count !== CW'(DEPTH) || s_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL pulse_refill got=cnt%0d/rdy%b want=cnt%0d/rdy0", count, s_ready, DEPTH);
    end
    for (int i = 0; i < 40 && model.size() > 0; i++) begin
      total++;
      if (m_valid !== 1'b1 || m_data !== model[0]) begin
        bad++; $display("[TB] FAIL pulse_drain got=valid%b/%0d want=valid1/%0d", m_valid, m_data, model[0]);
      end
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    total++;
    if (count !== '0) begin bad++; $display("[TB] FAIL pulse_empty got=%0d want=0", count); end
  endtask

  task automatic test_random_backpressure();
    int pushed = 0;
    int cyc = 0;
    logic sv;
    logic mr;
    logic [31:0] sd;
    while ((pushed < 1000 || model.size() > 0) && cyc < 20000) begin
      sv = (pushed < 1000) && ($urandom_range(0, 3) != 0);
      mr = 1'($urandom_range(0, 1));
      sd = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      applyStimulus(sv, sd, mr, 1'b0, 1'b0);
      if (last_push) pushed++;
      cyc++;
      total++;
      if (m_valid !== (model.size() > 0)) begin
        bad++; $display("[TB] FAIL rand_m_valid cyc=%0d got=%b want=%b", cyc, m_valid, model.size() > 0);
      end
      if (model.size() > 0) begin
        total++;
        if (m_data !== model[0]) begin bad++; $display("[TB] FAIL rand_m_data cyc=%0d got=%h want=%h", cyc, m_data, model[0]); end
      end
      total++;
      if (count !== CW'(model.size())) begin
        bad++; $display("[TB] FAIL rand_count cyc=%0d got=%0d want=%0d", cyc, count, model.size());
      end
      total++;
      if (s_ready !== (model.size() < DEPTH) || almost_full !== (model.size() >= AFULL_TH) ||
          almost_empty !== (model.size() <= AEMPTY_TH)) begin
        bad++; $display("[TB] FAIL rand_flags cyc=%0d got=%b%b%b cnt=%0d", cyc, s_ready, almost_full, almost_empty, model.size());
      end
    end
    total++;
    if (cyc >= 20000) begin bad++; $display("[TB] FAIL rand_timeout got=%0d want<20000", cyc); end
  endtask

  task automatic test_flush_and_reset();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 9; i++) applyStimulus(1'b1, 32'hC00 + 32'(i), 1'b0, 1'b0, 1'b0);
      total++;
      if (count !== CW'(9)) begin bad++; $display("[TB] FAIL clr_pre_count pass=%0d got=%0d want=9", pass, count); end
      if (pass == 0) begin
        flush = 1'b1;
        s_valid = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b0) begin bad++; $display("[TB] FAIL flush_s_ready got=%b want=0", s_ready); end
      end
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, pass == 0, pass == 1);
      total++;
      if (count !== '0 || m_valid !== 1'b0) begin
        bad++; $display("[TB] FAIL clr_state pass=%0d got=cnt%0d/valid%b want=cnt0/valid0", pass, count, m_valid);
      end
      applyStimulus(1'b1, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
      total++;
      if (m_valid !== 1'b1 || m_data !== 32'h0000_1234 || count !== CW'(1)) begin
        bad++; $display("[TB] FAIL clr_first pass=%0d got=valid%b/%h/cnt%0d want=valid1/00001234/cnt1", pass, m_valid, m_data, count);
      end
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      total++;
      if (m_valid !== 1'b0 || count !== '0) begin
        bad++; $display("[TB] FAIL clr_after pass=%0d got=valid%b/cnt%0d want=valid0/cnt0", pass, m_valid, count);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    m_ready = 1'b0;
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_full_pulse();
    test_random_backpressure();
    test_flush_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
